// File: rtl/ling_eac_adder_pipe_if.sv
// Operand/result handshake bundle for ling_eac_adder_pipe.
// The master side supplies operands and accepts results; the adder is the slave.
interface ling_eac_adder_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             mode_eac;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, mode_eac, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, mode_eac, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/ling_eac_adder_pipe.sv
// Three-stage pipelined radix-4 Ling prefix adder.
// Each transaction selects end-around-carry (mod 2^W-1) or plain mod 2^W addition.
module ling_eac_adder_pipe #(
    parameter int WIDTH     = 16,
    parameter bit ZERO_NORM = 1'b0
) (
    input logic                  clk,
    input logic                  rst_n,
    ling_eac_adder_pipe_if.slave bus
);
    localparam int IDXW   = $clog2(WIDTH);
    localparam int LEVELS = (WIDTH <= 16) ? 2 : 3;

    generate
        if (WIDTH != 8 && WIDTH != 16 && WIDTH != 32 && WIDTH != 64) begin : g_bad_width
            $error("ling_eac_adder_pipe: WIDTH must be 8, 16, 32 or 64");
        end
    endgenerate

    // Bit j of a prefix vector; negative j wraps cyclically in EAC mode, otherwise reads fill.
    function automatic logic pick(input logic [WIDTH-1:0] v, input int j,
                                  input logic eac, input logic fill);
        logic r;
        if (j >= 0)   r = v[IDXW'(j)];
        else if (eac) r = v[IDXW'(j + 4 * WIDTH)];
        else          r = fill;
        return r;
    endfunction

    logic             advance;
    logic             v1, v2, v3;
    logic [WIDTH-1:0] t1, x1, h1_q, pr1_q;
    logic             eac1, cin1;
    logic [WIDTH-1:0] t2, x2, hf2;
    logic             eac2, cin2;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic [WIDTH-1:0] g_c, t_c, h1_c, pr1_c, hf_c, cy_c, sum_c;
    logic             top_c, cout_c;

    assign advance       = bus.out_ready | ~v3;
    assign bus.in_ready  = advance;
    assign bus.out_valid = v3;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

    // H_i = g_i | t_{i-1} & H_{i-1}. In mod 2^W mode cin is folded into g_0, so the
    // prefix never has to reach below bit 0 and W bits of span suffice.
    always_comb begin
        t_c = bus.a | bus.b;
        g_c = bus.a & bus.b;
        if (!bus.mode_eac) g_c[0] = g_c[0] | (t_c[0] & bus.cin);
        h1_c  = '0;
        pr1_c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            logic h, pp;
            h  = 1'b0;
            pp = 1'b1;
            for (int unsigned k = 0; k < 4; k++) begin
                h  = h | (pp & pick(g_c, int'(i) - int'(k), bus.mode_eac, 1'b0));
                pp = pp & pick(t_c, int'(i) - int'(k) - 1, bus.mode_eac, 1'b1);
            end
            h1_c[i]  = h;
            pr1_c[i] = pp;
        end
    end

    always_comb begin : s2_prefix
        logic [WIDTH-1:0] hc, pc, hn, pn;
        hc = h1_q;
        pc = pr1_q;
        hn = '0;
        pn = '0;
        for (int unsigned lvl = 1; lvl < LEVELS; lvl++) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                logic h, pp;
                int   j;
                h  = 1'b0;
                pp = 1'b1;
                j  = 0;
                for (int unsigned k = 0; k < 4; k++) begin
                    j  = int'(i) - int'(k << (2 * lvl));
                    h  = h | (pp & pick(hc, j, eac1, 1'b0));
                    pp = pp & pick(pc, j, eac1, 1'b1);
                end
                hn[i] = h;
                pn[i] = pp;
            end
            hc = hn;
            pc = pn;
        end
        hf_c = hc;
    end

    // Carry into bit i is t_{i-1} & H_{i-1}; bit 0 takes the wrapped carry or cin.
    always_comb begin
        top_c  = t2[WIDTH-1] & hf2[WIDTH-1];
        cy_c   = {t2[WIDTH-2:0] & hf2[WIDTH-2:0], eac2 ? top_c : cin2};
        sum_c  = x2 ^ cy_c;
        if (ZERO_NORM && eac2 && (&sum_c)) sum_c = '0;
        cout_c = ~eac2 & top_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            v3     <= 1'b0;
            t1     <= '0;
            x1     <= '0;
            h1_q   <= '0;
            pr1_q  <= '0;
            eac1   <= 1'b0;
            cin1   <= 1'b0;
            t2     <= '0;
            x2     <= '0;
            hf2    <= '0;
            eac2   <= 1'b0;
            cin2   <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (advance) begin
            v1     <= bus.in_valid;
            t1     <= t_c;
            x1     <= bus.a ^ bus.b;
            h1_q   <= h1_c;
            pr1_q  <= pr1_c;
            eac1   <= bus.mode_eac;
            cin1   <= bus.cin;
            v2     <= v1;
            t2     <= t1;
            x2     <= x1;
            hf2    <= hf_c;
            eac2   <= eac1;
            cin2   <= cin1;
            v3     <= v2;
            sum_q  <= sum_c;
            cout_q <= cout_c;
        end
    end
endmodule
